// File: rtl/chunked_seq_adder_if.sv
// Handshake and operand/result bundle for chunked_seq_adder.
// The master side issues operands and consumes results; the slave side is the adder.
interface chunked_seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock with the carry chained between
// cycles, valid/ready on both sides, and unsigned carry-out / signed overflow flags.
module chunked_seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    chunked_seq_adder_if.slave   bus,
    output logic                 busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int OFFW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              cout_q;
    logic              ovf_q;
    logic [IDXW-1:0]   idx_q;
    logic [OFFW-1:0]   off;
    logic              last;
    logic [CHUNK:0]    slice;

    // Bit offset of the current slice and the CHUNK+1-bit slice sum.
    always_comb begin
        off   = OFFW'(int'(idx_q) * CHUNK);
        last  = (idx_q == IDXW'(NCHUNK - 1));
        slice = {1'b0, a_q[off +: CHUNK]} + {1'b0, b_q[off +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = RUN;
            RUN:     if (last)          state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[off +: CHUNK] <= slice[CHUNK-1:0];
                    carry_q             <= slice[CHUNK];
                    idx_q               <= idx_q + IDXW'(1);
                    // Final slice: slice[CHUNK-1] is the result MSB.
                    if (last) begin
                        cout_q <= slice[CHUNK];
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                               && (slice[CHUNK-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign busy          = (state != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_chunked_seq_adder.sv
// Randomized and directed bench for chunked_seq_adder at three geometries (4/1, 32/8, 16/16),
// checked every cycle against a transaction-level model of the adder.
module tb_chunked_seq_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0: WIDTH=4 CHUNK=1, 1: WIDTH=32 CHUNK=8, 2: WIDTH=16 CHUNK=16
    logic        iv   [3];
    logic [31:0] ia   [3];
    logic [31:0] ib   [3];
    logic        ic   [3];
    logic        ordy [3];
    logic        busy4, busy32, busy16;

    chunked_seq_adder_if #(.WIDTH(4))  i4  ();
    chunked_seq_adder_if #(.WIDTH(32)) i32 ();
    chunked_seq_adder_if #(.WIDTH(16)) i16 ();

    chunked_seq_adder #(.WIDTH(4),  .CHUNK(1))  u4  (.clk(clk), .rst(rst), .bus(i4.slave),  .busy(busy4));
    chunked_seq_adder #(.WIDTH(32), .CHUNK(8))  u32 (.clk(clk), .rst(rst), .bus(i32.slave), .busy(busy32));
    chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) u16 (.clk(clk), .rst(rst), .bus(i16.slave), .busy(busy16));

    assign i4.in_valid   = iv[0];
    assign i4.a          = ia[0][3:0];
    assign i4.b          = ib[0][3:0];
    assign i4.cin        = ic[0];
    assign i4.out_ready  = ordy[0];
    assign i32.in_valid  = iv[1];
    assign i32.a         = ia[1];
    assign i32.b         = ib[1];
    assign i32.cin       = ic[1];
    assign i32.out_ready = ordy[1];
    assign i16.in_valid  = iv[2];
    assign i16.a         = ia[2][15:0];
    assign i16.b         = ib[2][15:0];
    assign i16.cin       = ic[2];
    assign i16.out_ready = ordy[2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic        m_ready [3];
    logic        m_valid [3];
    logic        m_clean [3];
    int          m_left  [3];
    logic [33:0] m_res   [3];
    logic [33:0] m_pend  [3];

    function automatic int w_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 32 : 16;
    endfunction

    function automatic int nc_of(input int s);
        return (s == 2) ? 1 : 4;
    endfunction

    // {ovf, cout, sum} of a w-bit add, straight from integer arithmetic.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic c);
        logic [31:0] m, s, am, bm;
        logic [32:0] full;
        logic        co, ov;
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am   = a & m;
        bm   = b & m;
        full = {1'b0, am} + {1'b0, bm} + {32'd0, c};
        s    = full[31:0] & m;
        co   = full[6'(w)];
        ov   = (am[5'(w - 1)] == bm[5'(w - 1)]) && (s[5'(w - 1)] != am[5'(w - 1)]);
        return {ov, co, s};
    endfunction

    function automatic logic rdy(input int s);
        case (s)
            0:       return i4.in_ready;
            1:       return i32.in_ready;
            default: return i16.in_ready;
        endcase
    endfunction

    function automatic logic vld(input int s);
        case (s)
            0:       return i4.out_valid;
            1:       return i32.out_valid;
            default: return i16.out_valid;
        endcase
    endfunction

    function automatic logic bsy(input int s);
        case (s)
            0:       return busy4;
            1:       return busy32;
            default: return busy16;
        endcase
    endfunction

    function automatic logic [33:0] out_res(input int s);
        case (s)
            0:       return {i4.ovf, i4.cout, 28'd0, i4.sum};
            1:       return {i32.ovf, i32.cout, i32.sum};
            default: return {i16.ovf, i16.cout, 16'd0, i16.sum};
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model: accept when ready, result appears NCHUNK edges later, held until taken.
    always @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (rst) begin
                m_ready[s] <= 1'b1;
                m_valid[s] <= 1'b0;
                m_clean[s] <= 1'b1;
                m_left[s]  <= 0;
                m_res[s]   <= '0;
            end else if (m_ready[s]) begin
                if (iv[s]) begin
                    m_ready[s] <= 1'b0;
                    m_clean[s] <= 1'b0;
                    m_left[s]  <= nc_of(s);
                    m_pend[s]  <= ref_add(w_of(s), ia[s], ib[s], ic[s]);
                end
            end else if (m_left[s] > 0) begin
                m_left[s] <= m_left[s] - 1;
                if (m_left[s] == 1) begin
                    m_valid[s] <= 1'b1;
                    m_res[s]   <= m_pend[s];
                end
            end else if (m_valid[s] && ordy[s]) begin
                m_valid[s] <= 1'b0;
                m_ready[s] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int s = 0; s < 3; s++) begin
                check($sformatf("in_ready[%0d]", s), 64'(rdy(s)), 64'(m_ready[s]));
                check($sformatf("out_valid[%0d]", s), 64'(vld(s)), 64'(m_valid[s]));
                check($sformatf("busy[%0d]", s), 64'(bsy(s)), 64'(!m_ready[s]));
                if (m_valid[s] || m_clean[s])
                    check($sformatf("result[%0d]", s), 64'(out_res(s)), 64'(m_res[s]));
            end
        end
    end

    task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b, input logic c,
                          input int stall, output logic [33:0] res);
        int lat;
        bit ok;
        ia[s]   = a;
        ib[s]   = b;
        ic[s]   = c;
        iv[s]   = 1'b1;
        ordy[s] = (stall == 0);
        res     = '0;
        ok      = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = rdy(s);
        end
        check($sformatf("accept[%0d]", s), 64'(ok), 64'(1));
        if (!ok) begin
            iv[s] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 iv[s] = 1'b0;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = vld(s);
            if (!ok) lat++;
        end
        check($sformatf("latency[%0d]", s), 64'(lat), 64'(nc_of(s)));
        res = out_res(s);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            ordy[s] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] res;
        logic [33:0] exp;
        logic [31:0] a0, b0;
        logic        c0;
        bit          ok;
        for (int s = 0; s < 3; s++) begin
            iv[s] = 1'b0; ia[s] = '0; ib[s] = '0; ic[s] = 1'b0; ordy[s] = 1'b0;
        end

        // Hand-computed pins on the reference arithmetic
        check("pin_ripple", 64'(ref_add(32, 32'hFFFF_FFFF, 32'h1, 1'b0)), 64'({1'b0, 1'b1, 32'h0000_0000}));
        check("pin_posovf", 64'(ref_add(32, 32'h7FFF_FFFF, 32'h0, 1'b1)), 64'({1'b1, 1'b0, 32'h8000_0000}));
        check("pin_negovf", 64'(ref_add(32, 32'h8000_0000, 32'h8000_0000, 1'b0)), 64'({1'b1, 1'b1, 32'h0}));
        check("pin_w16",    64'(ref_add(16, 32'hFFFF, 32'hFFFF, 1'b1)), 64'({1'b0, 1'b1, 32'h0000_FFFF}));
        check("pin_w4",     64'(ref_add(4, 32'h7, 32'h1, 1'b0)), 64'({1'b1, 1'b0, 32'h8}));

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed 32/8 corner cases
        run_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, res);
        check("ripple32", 64'(res), 64'({1'b0, 1'b1, 32'h0000_0000}));
        run_op(1, 32'h7FFF_FFFF, 32'h0, 1'b1, 0, res);
        check("posovf32", 64'(res), 64'({1'b1, 1'b0, 32'h8000_0000}));
        run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 2, res);
        check("negovf32", 64'(res), 64'({1'b1, 1'b1, 32'h0}));

        // Backpressure with in_valid held and operands churning
        a0 = 32'h1234_5678; b0 = 32'h0FED_CBA9; c0 = 1'b1;
        exp = ref_add(32, a0, b0, c0);
        ia[1] = a0; ib[1] = b0; ic[1] = c0; iv[1] = 1'b1; ordy[1] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rdy(1);
        end
        check("bp_accept", 64'(ok), 64'(1));
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #1 ia[1] = $urandom; ib[1] = $urandom;
            @(negedge clk);
            ok = vld(1);
        end
        check("bp_valid", 64'(ok), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 ia[1] = $urandom; ib[1] = $urandom; ic[1] = 1'($urandom);
            @(negedge clk);
            check("bp_hold_valid", 64'(vld(1)), 64'(1));
            check("bp_hold_ready", 64'(rdy(1)), 64'(0));
            check("bp_hold_res", 64'(out_res(1)), 64'(exp));
        end
        run_op(1, 32'hA5A5_0001, 32'h5A5A_FFFF, 1'b0, 0, res);
        check("bp_next", 64'(res), 64'({1'b0, 1'b1, 32'h0}));

        // Reset while the operation is at slice index 2
        ia[1] = 32'hFFFF_FFFF; ib[1] = 32'h1; ic[1] = 1'b1; iv[1] = 1'b1; ordy[1] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rdy(1);
        end
        check("rr_accept", 64'(ok), 64'(1));
        @(posedge clk);
        #1 iv[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rr_ready", 64'(rdy(1)), 64'(1));
        check("rr_valid", 64'(vld(1)), 64'(0));
        check("rr_busy", 64'(bsy(1)), 64'(0));
        check("rr_sum", 64'(out_res(1)), 64'(0));
        run_op(1, 32'd5, 32'd7, 1'b0, 0, res);
        check("rr_after", 64'(res), 64'({1'b0, 1'b0, 32'd12}));

        // Randomized 32/8 with random output stalls
        for (int n = 0; n < 150; n++) begin
            a0 = rand_opnd(); b0 = rand_opnd(); c0 = 1'($urandom);
            run_op(1, a0, b0, c0, $urandom_range(0, 3), res);
            check("rand32", 64'(res), 64'(ref_add(32, a0, b0, c0)));
        end

        // Single-cycle geometry 16/16
        run_op(2, 32'hFFFF, 32'hFFFF, 1'b1, 0, res);
        check("full16", 64'(res), 64'({1'b0, 1'b1, 32'h0000_FFFF}));
        for (int n = 0; n < 30; n++) begin
            a0 = rand_opnd() & 32'hFFFF; b0 = rand_opnd() & 32'hFFFF; c0 = 1'($urandom);
            run_op(2, a0, b0, c0, $urandom_range(0, 2), res);
            check("rand16", 64'(res), 64'(ref_add(16, a0, b0, c0)));
        end

        // Exhaustive bit-serial 4/1, out_ready held high
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    run_op(0, 32'(a), 32'(b), 1'(c), 0, res);
                    check("exh4", 64'(res), 64'(ref_add(4, 32'(a), 32'(b), 1'(c))));
                end
            end
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/chunked_seq_adder.md
Name: chunked_seq_adder

Overview:
- Parametrised multi-cycle adder; successor to the team's single-bit combinational adder cells.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, with the carry chained between cycles.
- Valid/ready handshake on input and output, so it drops into datapaths that need area-cheap wide addition.
- Flags unsigned carry-out and signed overflow.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of slice cycles per operation.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything and forces:
  - state to IDLE;
  - in_ready=1, out_valid=0, busy=0;
  - sum=0, cout=0, ovf=0;
  - internal chunk index and carry to 0.
- Reset mid-operation discards the operation; no out_valid is produced for it.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready at an edge: latch a, b and cin; clear idx; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle: {c, s} = a[idx*CHUNK +: CHUNK] + b[idx*CHUNK +: CHUNK] + carry (CHUNK+1-bit add).
  - Write s into sum[idx*CHUNK +: CHUNK], set carry <= c, increment idx.
  - When idx == NCHUNK-1: set cout <= c, set ovf <= (a[MSB] == b[MSB]) && (s[CHUNK-1] != a[MSB]) using the latched a and b, and go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - When out_ready is sampled high at an edge: out_valid <= 0 and go to IDLE.
- No bypass: a new operation cannot be accepted in the same cycle as the DONE handshake. Minimum issue interval is NCHUNK+2 cycles.
- Latency: out_valid rises NCHUNK edges after the accepting edge. With CHUNK == WIDTH this is 1 edge.
- Before an operation completes, sum holds a mix of new and previous slices and is only meaningful while out_valid=1.
- Backpressure: out_valid stays high and outputs stay frozen indefinitely while out_ready=0.
- out_ready while out_valid=0 is ignored.
- Wrap-around: the result is modulo 2^WIDTH; any carry beyond the MSB appears only on cout.
- Inputs containing X/Z are not a supported case.

Test Plan:
- WIDTH=4, CHUNK=1, out_ready tied 1: exhaustive a, b in 0..15, cin in {0,1} (512 ops) -> {cout, sum} == a+b+cin each op; ovf matches the signed check; out_valid exactly 4 cycles after each accept.
- WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0; carry ripples through all 4 chunks; out_valid 4 cycles after accept.
- WIDTH=32, CHUNK=8: a=0x7FFFFFFF, b=0x00000000, cin=1 -> sum=0x80000000, cout=0, ovf=1; then a=0x80000000, b=0x80000000, cin=0 -> sum=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and changing a/b throughout -> out_valid, sum and cout stay constant; in_ready=0; new operands are not latched until after the DONE handshake and return to IDLE.
- Reset mid-RUN: assert rst for 1 cycle at idx=2 -> next cycle in_ready=1, out_valid=0, busy=0, sum=0; a following op with a=5, b=7 returns sum=12 with no stale carry.
- CHUNK=WIDTH=16: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0; out_valid 1 cycle after accept.
